obi_sram_arbiter: RTL and testbench

OBI_SRAM_ARBITER -- requirements
Module: obi_sram_arbiter

---
 rtl/obi_sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_obi_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM between NumReq OBI requesters.
// Optional macro OBI_SRAM_ARB_RANGE_CHECK_EN: out-of-window addresses get an error response instead of an SRAM access.
module obi_sram_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter logic [31:0] BaseAddr  = 32'h0,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned SramAddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             m_req_i,
  output logic [NumReq-1:0]             m_gnt_o,
  input  logic [NumReq*32-1:0]          m_addr_i,
  input  logic [NumReq-1:0]             m_we_i,
  input  logic [NumReq*BeWidth-1:0]     m_be_i,
  input  logic [NumReq*DataWidth-1:0]   m_wdata_i,
  output logic [NumReq-1:0]             m_rvalid_o,
  output logic [DataWidth-1:0]          m_rdata_o,
  output logic [NumReq-1:0]             m_err_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [BeWidth-1:0]            s_be_o,
  output logic [SramAddrWidth-1:0]      s_addr_o,
  output logic [DataWidth-1:0]          s_wdata_o,
  input  logic [DataWidth-1:0]          s_rdata_i
);

  localparam int unsigned         IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumReq - 1);

  logic [IdxWidth-1:0]  r_rr;
  logic [IdxWidth-1:0]  w_rr_nxt;
  logic [IdxWidth-1:0]  w_hi_idx;
  logic [IdxWidth-1:0]  w_lo_idx;
  logic                 w_hi_found;
  logic                 w_lo_found;
  logic                 w_win_valid;
  logic [IdxWidth-1:0]  w_win_idx;

  logic [31:0]          w_sel_addr;
  logic                 w_sel_we;
  logic [BeWidth-1:0]   w_sel_be;
  logic [DataWidth-1:0] w_sel_wdata;
  logic [31:0]          w_off;
  logic                 w_range_err;

  logic                 r_rsp_valid;
  logic [IdxWidth-1:0]  r_rsp_idx;
  logic                 r_rsp_err;

  // Lowest request at or above the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (m_req_i[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IdxWidth'(i);
        if (IdxWidth'(i) >= r_rr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IdxWidth'(i);
        end
      end
    end
  end

  assign w_win_valid = w_lo_found;
  assign w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  assign m_gnt_o     = w_win_valid ? (NumReq'(1) << w_win_idx) : '0;

  always_comb begin
    w_rr_nxt = r_rr;
    if (w_win_valid) begin
      w_rr_nxt = (w_win_idx == LastIdx) ? '0 : (w_win_idx + IdxWidth'(1));
    end
  end

  // Route the winner's transaction fields to the SRAM port.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (w_win_idx == IdxWidth'(k)) begin
        w_sel_addr  = m_addr_i[32*k +: 32];
        w_sel_we    = m_we_i[k];
        w_sel_be    = m_be_i[BeWidth*k +: BeWidth];
        w_sel_wdata = m_wdata_i[DataWidth*k +: DataWidth];
      end
    end
  end

  assign w_off     = w_sel_addr - BaseAddr;
  assign s_addr_o  = SramAddrWidth'(w_off >> 2);
  assign s_we_o    = w_sel_we;
  assign s_be_o    = w_sel_be;
  assign s_wdata_o = w_sel_wdata;

`ifdef OBI_SRAM_ARB_RANGE_CHECK_EN
  localparam logic [33:0] UpperAddr = 34'(BaseAddr) + (34'(NumWords) << 2);

  logic w_in_range;

  assign w_in_range  = (w_sel_addr >= BaseAddr) && ({2'b00, w_sel_addr} < UpperAddr);
  assign w_range_err = w_win_valid & ~w_in_range;
`else
  assign w_range_err = 1'b0;
`endif

  assign s_req_o = w_win_valid & ~w_range_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rr        <= w_rr_nxt;
      r_rsp_valid <= w_win_valid;
      r_rsp_idx   <= w_win_idx;
      r_rsp_err   <= w_range_err;
    end
  end

  // Response decode: one-hot valid for the remembered winner, data only for a clean response.
  assign m_rvalid_o = r_rsp_valid ? (NumReq'(1) << r_rsp_idx) : '0;
  assign m_rdata_o  = (r_rsp_valid && !r_rsp_err) ? s_rdata_i : '0;

`ifdef OBI_SRAM_ARB_RANGE_CHECK_EN
  assign m_err_o = (r_rsp_valid && r_rsp_err) ? (NumReq'(1) << r_rsp_idx) : '0;
`else
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Self-checking bench for obi_sram_arbiter: directed vectors, a transaction-level model and a behavioural SRAM.
module tb_obi_sram_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned NW   = 1024;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned AW   = 10;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef OBI_SRAM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    req = '0;
  logic [31:0]     addr  [N];
  logic [N-1:0]    we = '0;
  logic [BW-1:0]   be    [N];
  logic [DW-1:0]   wdata [N];

  logic [N*32-1:0] m_addr;
  logic [N*BW-1:0] m_be;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt_o, m_rvalid_o, m_err_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o, s_we_o;
  logic [BW-1:0]   s_be_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [DW-1:0]   s_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      m_addr[32*k +: 32]  = addr[k];
      m_be[BW*k +: BW]    = be[k];
      m_wdata[DW*k +: DW] = wdata[k];
    end
  end

  obi_sram_arbiter #(
    .NumReq(N), .NumWords(NW), .DataWidth(DW), .BaseAddr(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(req), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr), .m_we_i(we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Behavioural SRAM with one cycle of read latency.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (s_req_o) begin
      if (s_we_o) begin
        for (int b = 0; b < BW; b++)
          if (s_be_o[b]) sram[s_addr_o][8*b +: 8] <= s_wdata_o[8*b +: 8];
      end else begin
        s_rdata <= sram[s_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: pointer as an integer, one pending response, a shadow memory.
  logic [DW-1:0] ref_mem [NW];
  int            rr_m  = 0;
  bit            pv    = 1'b0;
  int            pidx  = 0;
  bit            perr  = 1'b0;
  bit            pwe   = 1'b0;
  logic [DW-1:0] pdata = '0;

  always @(negedge clk) begin
    int          win;
    int          c;
    int          w;
    bit          e_err;
    logic [31:0] off;
    if (rst) begin
      pv   = 1'b0;
      rr_m = 0;
      chk("rst_rvalid", 64'(m_rvalid_o), 64'(0));
      chk("rst_err", 64'(m_err_o), 64'(0));
      chk("rst_rdata", 64'(m_rdata_o), 64'(0));
    end else begin
      chk("rvalid", 64'(m_rvalid_o), pv ? 64'(1) << pidx : 64'(0));
      chk("err", 64'(m_err_o), (pv && perr) ? 64'(1) << pidx : 64'(0));
      if (!pv || perr) chk("rdata_zero", 64'(m_rdata_o), 64'(0));
      else if (!pwe)   chk("rdata", 64'(m_rdata_o), 64'(pdata));
    end
    win = -1;
    for (int i = 0; i < N; i++) begin
      c = (rr_m + i) % N;
      if (win < 0 && req[c]) win = c;
    end
    chk("gnt", 64'(m_gnt_o), (win >= 0) ? 64'(1) << win : 64'(0));
    if (win >= 0) begin
      off   = addr[win] - BASE;
      e_err = RC && !((addr[win] >= BASE) && (off < 32'(4 * NW)));
      w     = int'(off >> 2) % NW;
      chk("s_req", 64'(s_req_o), 64'(!e_err));
      if (!e_err) begin
        chk("s_addr", 64'(s_addr_o), 64'(w));
        chk("s_we", 64'(s_we_o), 64'(we[win]));
        chk("s_be", 64'(s_be_o), 64'(be[win]));
        if (we[win]) chk("s_wdata", 64'(s_wdata_o), 64'(wdata[win]));
      end
      if (!rst) begin
        pv    = 1'b1;
        pidx  = win;
        perr  = e_err;
        pwe   = we[win];
        pdata = ref_mem[w];
        if (we[win] && !e_err)
          for (int b = 0; b < BW; b++)
            if (be[win][b]) ref_mem[w][8*b +: 8] = wdata[win][8*b +: 8];
        rr_m = (win + 1) % N;
      end
    end else begin
      chk("s_req_idle", 64'(s_req_o), 64'(0));
      if (!rst) pv = 1'b0;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] cg [4];
    cg = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < NW; i++) begin
      sram[i]    = pat(i);
      ref_mem[i] = pat(i);
    end
    for (int k = 0; k < N; k++) begin
      addr[k]  = BASE;
      be[k]    = '1;
      wdata[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("lit_rst_rvalid", 64'(m_rvalid_o), 64'(0));
    chk("lit_rst_gnt", 64'(m_gnt_o), 64'(0));
    nxt(); rst = 1'b0;

    // Single read of word 4
    nxt(); req = 2'b01; addr[0] = BASE + 32'h10;
    mid(); chk("lit_rd_gnt", 64'(m_gnt_o), 64'(2'b01)); chk("lit_rd_saddr", 64'(s_addr_o), 64'(4));
    nxt(); req = 2'b00;
    mid(); chk("lit_rd_rvalid", 64'(m_rvalid_o), 64'(2'b01)); chk("lit_rd_rdata", 64'(m_rdata_o), 64'h0000_0000_C0DE_0004);

    // Contention straight out of reset
    nxt(); rst = 1'b1;
    mid();
    nxt(); rst = 1'b0; req = 2'b11; addr[0] = BASE + 32'h20; addr[1] = BASE + 32'h40;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      mid();
      chk("lit_cont_gnt", 64'(m_gnt_o), 64'(cg[i]));
      if (i > 0) chk("lit_cont_rvalid", 64'(m_rvalid_o), 64'(cg[i-1]));
    end
    nxt(); req = 2'b00;
    mid(); chk("lit_cont_last_rvalid", 64'(m_rvalid_o), 64'(2'b10));

    // Write from requester 1, then read back with unaligned address bits
    nxt(); req = 2'b10; we[1] = 1'b1; be[1] = 4'b0011; wdata[1] = 32'hA5A5_1234; addr[1] = BASE + 32'h30;
    mid(); chk("lit_wr_swe", 64'(s_we_o), 64'(1)); chk("lit_wr_sbe", 64'(s_be_o), 64'(4'b0011));
    chk("lit_wr_swdata", 64'(s_wdata_o), 64'h0000_0000_A5A5_1234);
    nxt(); req = 2'b01; we = '0; addr[0] = BASE + 32'h33;
    mid(); chk("lit_wr_rvalid", 64'(m_rvalid_o), 64'(2'b10)); chk("lit_wr_err", 64'(m_err_o), 64'(0));
    chk("lit_unaligned_saddr", 64'(s_addr_o), 64'(12));
    nxt(); req = 2'b00;
    mid(); chk("lit_rdback", 64'(m_rdata_o), 64'h0000_0000_C0DE_1234);

    // Just past the top of the window
    nxt(); req = 2'b01; addr[0] = BASE + 32'(4 * NW);
    mid(); chk("lit_top_gnt", 64'(m_gnt_o), 64'(2'b01));
    if (RC) chk("lit_top_sreq", 64'(s_req_o), 64'(0));
    else    chk("lit_top_saddr", 64'(s_addr_o), 64'(0));
    nxt(); req = 2'b00;
    mid(); chk("lit_top_rvalid", 64'(m_rvalid_o), 64'(2'b01));
    chk("lit_top_err", 64'(m_err_o), RC ? 64'(2'b01) : 64'(0));
    if (RC) chk("lit_top_rdata", 64'(m_rdata_o), 64'(0));

    // Just below the base
    nxt(); req = 2'b01; addr[0] = BASE - 32'd4;
    mid();
    if (RC) chk("lit_low_sreq", 64'(s_req_o), 64'(0));
    else    chk("lit_low_saddr", 64'(s_addr_o), 64'(10'h3FF));
    nxt(); req = 2'b00;
    mid(); chk("lit_low_err", 64'(m_err_o), RC ? 64'(2'b01) : 64'(0));

    // Reset lands between grant and response
    nxt(); req = 2'b10; addr[1] = BASE + 32'h8;
    mid(); chk("lit_mid_gnt", 64'(m_gnt_o), 64'(2'b10));
    nxt(); req = 2'b00; rst = 1'b1;
    mid(); chk("lit_mid_rvalid_rst", 64'(m_rvalid_o), 64'(0));
    rst = 1'b0;
    nxt(); req = 2'b11;
    mid(); chk("lit_mid_rvalid_after", 64'(m_rvalid_o), 64'(0)); chk("lit_mid_gnt_after", 64'(m_gnt_o), 64'(2'b01));
    nxt(); req = 2'b00;
    mid(); chk("lit_mid_resp", 64'(m_rvalid_o), 64'(2'b01));

    // Mixed burst; checked cycle by cycle by the model
    for (int i = 0; i < 32; i++) begin
      nxt();
      req      = 2'((i * 7 + 1) % 4);
      addr[0]  = BASE + 32'((i * 52) % 4096);
      addr[1]  = BASE + 32'((i * 36 + 8) % 4352);
      we[0]    = (i % 3 == 0);
      we[1]    = (i % 4 == 1);
      be[0]    = 4'(i + 1);
      be[1]    = 4'(15 - i);
      wdata[0] = 32'h1111_0000 + 32'(i);
      wdata[1] = 32'h2222_0000 + 32'(i * 3);
    end
    nxt(); req = 2'b00; we = '0;
    repeat (2) nxt();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
